// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the program counter, captures insmem words into an
// instruction register and hands them to the decoder over a VALID/READY handshake.
module fetch_ctrl #(
   parameter int unsigned AddressWidth = 4,
   parameter int unsigned DataWidth    = 8
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic [AddressWidth-1:0] ADD,
   input  logic [DataWidth-1:0]    DATAIN,
   output logic [DataWidth-1:0]    INSTR,
   output logic                    VALID,
   input  logic                    READY,
   input  logic                    JMP,
   input  logic [AddressWidth-1:0] JMPADD,
   input  logic                    HALT,
   output logic                    BUSY
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t                  r_state;
   logic [AddressWidth-1:0] r_add;
   logic [DataWidth-1:0]    r_instr;
   logic                    r_valid;
   logic                    r_busy;
   logic                    w_advance;

   // A new word may be loaded when the register is empty or being consumed this cycle.
   assign w_advance = !r_valid || READY;

   // HALT outranks JMP, which outranks the normal advance/stall path.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_add   <= '0;
         r_instr <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (START) begin
                  r_state <= ST_FETCH;
                  r_busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (HALT) begin
                  r_state <= ST_HALTED;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b0;
               end else if (JMP) begin
                  r_add   <= JMPADD;
                  r_valid <= 1'b0;
               end else if (w_advance) begin
                  r_instr <= DATAIN;
                  r_valid <= 1'b1;
                  r_add   <= r_add + AddressWidth'(1);
               end
            end
            ST_HALTED: begin
               r_state <= ST_HALTED;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign ADD   = r_add;
   assign INSTR = r_instr;
   assign VALID = r_valid;
   assign BUSY  = r_busy;

endmodule
